// File: rtl/aes_key_sched_ctrl.sv
// Key-schedule sequencer for one AES block: pulses key expansion LOAD, then presents
// round keys forward (encrypt) or, after a forward expansion pass, in reverse (decrypt).
module aes_key_sched_ctrl #(
  parameter int unsigned IDX_W  = 4,
  parameter int unsigned NR_128 = 10,
  parameter int unsigned NR_192 = 12,
  parameter int unsigned NR_256 = 14
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic             decrypt,
  input  logic             abort,
  output logic             ready,
  output logic             busy,
  output logic             ke_load,
  output logic             ke_revers,
  output logic [1:0]       ke_mode,
  output logic             key_valid,
  output logic [IDX_W-1:0] round_idx,
  output logic             first_round,
  output logic             last_round,
  output logic             done
);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StRoundFwd,
    StExpand,
    StRoundRev,
    StDone
  } state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic [1:0]       mode_q, mode_d;
  logic             dec_q, dec_d;
  logic [IDX_W-1:0] nr;

  logic ready_d, load_d, revers_d, valid_d, first_d, last_d, done_d;

  // Latched mode is already folded (3 -> 2), so only three cases remain.
  always_comb begin
    case (mode_q)
      2'd0:    nr = IDX_W'(NR_128);
      2'd1:    nr = IDX_W'(NR_192);
      default: nr = IDX_W'(NR_256);
    endcase
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    dec_d   = dec_q;

    unique case (state_q)
      StIdle: begin
        if (start && !abort) begin
          state_d = StLoad;
          mode_d  = (mode == 2'd3) ? 2'd2 : mode;
          dec_d   = decrypt;
          idx_d   = '0;
          cnt_d   = '0;
        end
      end
      StLoad: begin
        state_d = dec_q ? StExpand : StRoundFwd;
      end
      StRoundFwd: begin
        if (idx_q == nr) begin
          state_d = StDone;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      StExpand: begin
        if (cnt_q == nr - 1'b1) begin
          state_d = StRoundRev;
          idx_d   = nr;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StRoundRev: begin
        if (idx_q == '0) begin
          state_d = StDone;
        end else begin
          idx_d = idx_q - 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (abort && (state_q != StIdle)) begin
      state_d = StIdle;
      idx_d   = '0;
      cnt_d   = '0;
    end

    // Outputs are decoded from the next state so they appear registered in the same cycle.
    ready_d  = (state_d == StIdle);
    load_d   = (state_d == StLoad);
    valid_d  = (state_d == StRoundFwd) || (state_d == StRoundRev);
    revers_d = (state_d == StRoundRev) && (idx_d != '0);
    first_d  = ((state_d == StRoundFwd) && (idx_d == '0)) ||
               ((state_d == StRoundRev) && (idx_d == nr));
    last_d   = ((state_d == StRoundFwd) && (idx_d == nr)) ||
               ((state_d == StRoundRev) && (idx_d == '0));
    done_d   = (state_d == StDone);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      cnt_q       <= '0;
      mode_q      <= 2'd0;
      dec_q       <= 1'b0;
      ready       <= 1'b1;
      ke_load     <= 1'b0;
      ke_revers   <= 1'b0;
      key_valid   <= 1'b0;
      first_round <= 1'b0;
      last_round  <= 1'b0;
      done        <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      mode_q      <= mode_d;
      dec_q       <= dec_d;
      ready       <= ready_d;
      ke_load     <= load_d;
      ke_revers   <= revers_d;
      key_valid   <= valid_d;
      first_round <= first_d;
      last_round  <= last_d;
      done        <= done_d;
    end
  end

  assign busy      = ~ready;
  assign ke_mode   = mode_q;
  assign round_idx = idx_q;

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// Bench for aes_key_sched_ctrl: a schedule-queue reference model checked every cycle,
// table-driven whole-operation vectors, hand-written reset/abort sequences and random traffic.
module tb_aes_key_sched_ctrl;

  logic       CLK, RST_N, start, decrypt, abort;
  logic [1:0] mode;
  logic       ready, busy, ke_load, ke_revers, key_valid, first_round, last_round, done;
  logic [1:0] ke_mode;
  logic [3:0] round_idx;

  aes_key_sched_ctrl dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .start      (start),
    .mode       (mode),
    .decrypt    (decrypt),
    .abort      (abort),
    .ready      (ready),
    .busy       (busy),
    .ke_load    (ke_load),
    .ke_revers  (ke_revers),
    .ke_mode    (ke_mode),
    .key_valid  (key_valid),
    .round_idx  (round_idx),
    .first_round(first_round),
    .last_round (last_round),
    .done       (done)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct packed {
    logic       ready;
    logic       busy;
    logic       ke_load;
    logic       ke_revers;
    logic [1:0] ke_mode;
    logic       key_valid;
    logic [3:0] round_idx;
    logic       first_round;
    logic       last_round;
    logic       done;
  } rec_t;

  typedef struct {
    logic [1:0] mode;
    logic       dec;
    int         abort_at;
    int         kv;
    int         done_cyc;
    int         rev;
    int         last_idx;
    logic [1:0] km;
  } vec_t;

  int   n_cmp = 0;
  int   n_bad = 0;
  rec_t cur;
  rec_t q[$];
  logic [1:0] m_mode;
  vec_t vecs[8];

  function automatic int nr_of(input logic [1:0] m);
    return (m == 2'd0) ? 10 : (m == 2'd1) ? 12 : 14;
  endfunction

  function automatic rec_t idle_rec();
    rec_t r = '0;
    r.ready   = 1'b1;
    r.ke_mode = m_mode;
    return r;
  endfunction

  function automatic string fmt(input rec_t r);
    return $sformatf("rdy=%b bsy=%b ld=%b rv=%b km=%0d kv=%b idx=%0d fr=%b lr=%b dn=%b",
                     r.ready, r.busy, r.ke_load, r.ke_revers, r.ke_mode, r.key_valid,
                     r.round_idx, r.first_round, r.last_round, r.done);
  endfunction

  // Expands an accepted operation into its full per-cycle output schedule.
  task automatic model_edge();
    rec_t base, r;
    int   nr;
    if (abort && !cur.ready) begin
      q.delete();
      cur = idle_rec();
    end else if (cur.ready && start && !abort) begin
      m_mode       = (mode == 2'd3) ? 2'd2 : mode;
      nr           = nr_of(m_mode);
      base         = '0;
      base.busy    = 1'b1;
      base.ke_mode = m_mode;
      cur          = base;
      cur.ke_load  = 1'b1;
      if (!decrypt) begin
        for (int i = 0; i <= nr; i++) begin
          r = base;
          r.key_valid   = 1'b1;
          r.round_idx   = 4'(i);
          r.first_round = (i == 0);
          r.last_round  = (i == nr);
          q.push_back(r);
        end
      end else begin
        for (int i = 0; i < nr; i++) q.push_back(base);
        for (int i = nr; i >= 0; i--) begin
          r = base;
          r.key_valid   = 1'b1;
          r.round_idx   = 4'(i);
          r.ke_revers   = (i > 0);
          r.first_round = (i == nr);
          r.last_round  = (i == 0);
          q.push_back(r);
        end
      end
      r      = base;
      r.done = 1'b1;
      q.push_back(r);
    end else if (q.size() > 0) begin
      cur = q.pop_front();
    end else begin
      cur = idle_rec();
    end
  endtask

  task automatic check_cur(input string tag);
    rec_t act;
    act.ready       = ready;
    act.busy        = busy;
    act.ke_load     = ke_load;
    act.ke_revers   = ke_revers;
    act.ke_mode     = ke_mode;
    act.key_valid   = key_valid;
    act.round_idx   = (cur.key_valid || cur.ke_load) ? round_idx : 4'd0;
    act.first_round = first_round;
    act.last_round  = last_round;
    act.done        = done;
    n_cmp++;
    if (act !== cur) begin
      n_bad++;
      $display("FAIL %s @%0t: got {%s} want {%s}", tag, $time, fmt(act), fmt(cur));
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic tick(input string tag);
    @(posedge CLK);
    model_edge();
    #1;
    check_cur(tag);
  endtask

  task automatic async_reset(input string tag);
    #2 RST_N = 1'b0;
    #1;
    q.delete();
    m_mode = 2'd0;
    cur    = idle_rec();
    check_cur(tag);
    @(negedge CLK);
    RST_N = 1'b1;
  endtask

  // Runs one operation with noisy inputs while busy; abort raised during cycle abort_at.
  task automatic run_op(input logic [1:0] m, input logic d, input int abort_at,
                        output int kv, output int done_cyc, output int rev,
                        output int last_idx, output logic [1:0] km);
    bit fin = 0;
    start = 1'b1; mode = m; decrypt = d; abort = 1'b0;
    tick("accept");
    kv = 0; done_cyc = 0; rev = 0; last_idx = -1; km = ke_mode;
    for (int k = 1; k <= 60 && !fin; k++) begin
      if (key_valid) kv++;
      if (done) done_cyc = k;
      if (ke_revers) rev++;
      if (last_round) last_idx = int'(round_idx);
      if (busy && ke_mode !== km) km = 2'bxx;
      if (cur.ready) begin
        fin = 1;
      end else begin
        start   = 1'($urandom);
        mode    = 2'($urandom);
        decrypt = 1'($urandom);
        abort   = (k == abort_at);
        tick("op");
      end
    end
    start = 1'b0; abort = 1'b0;
    if (!fin) begin
      n_cmp++;
      n_bad++;
      $display("FAIL op_timeout: got busy after 60 cycles want idle");
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "timeout");
  end

  initial begin
    int kv, dc, rv, li;
    logic [1:0] km;

    vecs[0] = '{2'd0, 1'b0, -1, 11, 13,  0, 10, 2'd0};
    vecs[1] = '{2'd2, 1'b1, -1, 15, 31, 14,  0, 2'd2};
    vecs[2] = '{2'd1, 1'b0, -1, 13, 15,  0, 12, 2'd1};
    vecs[3] = '{2'd1, 1'b1,  5,  0,  0,  0, -1, 2'd1};
    vecs[4] = '{2'd3, 1'b0, -1, 15, 17,  0, 14, 2'd2};
    vecs[5] = '{2'd0, 1'b1, -1, 11, 23, 10,  0, 2'd0};
    vecs[6] = '{2'd2, 1'b0,  8,  7,  0,  0, -1, 2'd2};
    vecs[7] = '{2'd3, 1'b1, -1, 15, 31, 14,  0, 2'd2};

    RST_N = 1'b0; start = 1'b0; mode = 2'd0; decrypt = 1'b0; abort = 1'b0;
    m_mode = 2'd0;
    cur    = idle_rec();
    #12;
    check_cur("por");
    @(negedge CLK);
    RST_N = 1'b1;
    tick("idle");

    foreach (vecs[i]) begin
      run_op(vecs[i].mode, vecs[i].dec, vecs[i].abort_at, kv, dc, rv, li, km);
      chk($sformatf("v%0d_kv_cycles", i), kv, vecs[i].kv);
      chk($sformatf("v%0d_done_cycle", i), dc, vecs[i].done_cyc);
      chk($sformatf("v%0d_revers_cycles", i), rv, vecs[i].rev);
      chk($sformatf("v%0d_last_idx", i), li, vecs[i].last_idx);
      chk($sformatf("v%0d_ke_mode", i), int'(km), int'(vecs[i].km));
      tick("gap");
    end

    // Reset in the middle of a forward walk, at round_idx 5.
    start = 1'b1; mode = 2'd0; decrypt = 1'b0;
    tick("accept_rst");
    start = 1'b0;
    repeat (6) tick("fwd_rst");
    chk("rst_pre_idx", int'(round_idx), 5);
    async_reset("rst_mid");
    chk("rst_ready", int'(ready), 1);
    run_op(2'd0, 1'b0, -1, kv, dc, rv, li, km);
    chk("post_rst_kv", kv, 11);
    chk("post_rst_done", dc, 13);

    // Start together with abort in idle stays idle.
    start = 1'b1; abort = 1'b1; mode = 2'd1; decrypt = 1'b1;
    tick("start_abort");
    chk("start_abort_ready", int'(ready), 1);
    start = 1'b0; abort = 1'b0;
    tick("start_abort_after");

    for (int c = 0; c < 600; c++) begin
      start   = ($urandom_range(0, 3) == 0);
      mode    = 2'($urandom);
      decrypt = 1'($urandom);
      abort   = ($urandom_range(0, 29) == 0);
      tick("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/aes_key_sched_ctrl.md
Name: aes_key_sched_ctrl

Overview:
- Sequences the key expansion block for one AES block operation.
- Pulses its LOAD to start expansion, tracks the round key it is presenting, and drives REVERS so decryption walks round keys from Nr down to 0.
- Tells the round datapath, one cycle at a time, which round key is valid and whether it is the first or last round.
- Sits between the top-level cipher FSM (start/done handshake) and the key expansion plus round datapath.

Parameters:
- IDX_W, 4, width of the round index; must hold 14.
- NR_128, 10, round count for mode 0 (AES-128).
- NR_192, 12, round count for mode 1 (AES-192).
- NR_256, 14, round count for mode 2 (AES-256).

Ports:
- CLK  in  1  system clock, rising edge.
- RST_N  in  1  asynchronous active-low reset.
- start  in  1  request a block operation; accepted when start && ready.
- mode  in  2  key size: 0=128, 1=192, 2=256, 3 treated as 2; sampled on accept.
- decrypt  in  1  1 = inverse key order; sampled on accept.
- abort  in  1  synchronous cancel of the current operation.
- ready  out  1  controller is idle and can accept start.
- busy  out  1  inverse of ready.
- ke_load  out  1  drives key expansion LOAD.
- ke_revers  out  1  drives key expansion REVERS.
- ke_mode  out  2  drives key expansion mode; the latched value, held stable while busy.
- key_valid  out  1  key expansion output is the round key for round_idx this cycle.
- round_idx  out  IDX_W  round number of the presented key (0..Nr).
- first_round  out  1  key_valid && this is the initial AddRoundKey.
- last_round  out  1  key_valid && this is the final round.
- done  out  1  one-cycle pulse after the last round key is presented.

Behaviour:
- Reset (RST_N low, any time, including mid-operation): state=IDLE; ready=1; every other output 0; ke_mode=0; latched mode/decrypt=0; counters=0.
- Nr = NR_128 / NR_192 / NR_256 per latched mode. Mode 3 behaves as 2, and ke_mode outputs 2.
- All outputs are registered or decoded from the current state and counters only; no combinational path from start, mode, decrypt or abort to any output.
- State IDLE: ready=1.
  - start && ready at edge E0 latches mode and decrypt and moves to LOAD.
  - start while busy is ignored; it is not queued.
- State LOAD (exactly 1 cycle): ke_load=1.
  - Next state: ROUND_FWD if encrypting, EXPAND if decrypting.
  - round_idx=0, cnt=0.
- State ROUND_FWD (Nr+1 cycles): key_valid=1, ke_revers=0.
  - round_idx counts 0,1,…,Nr, one per cycle.
  - first_round when round_idx==0; last_round when round_idx==Nr.
  - After the round_idx==Nr cycle, go to DONE.
  - No backpressure: the datapath consumes one key per cycle.
- State EXPAND (Nr cycles): key_valid=0; cnt counts 0..Nr-1 while key expansion runs forward.
  - Leaves when cnt==Nr-1 and moves to ROUND_REV with round_idx=Nr.
- State ROUND_REV (Nr+1 cycles): key_valid=1.
  - round_idx counts Nr, Nr-1, …, 0.
  - ke_revers=1 while round_idx>0 and 0 on the round_idx==0 cycle, so the expansion steps back one key per cycle.
  - first_round when round_idx==Nr; last_round when round_idx==0.
  - After the round_idx==0 cycle, go to DONE.
- State DONE (1 cycle): done=1, key_valid=0, then IDLE.
  - ready rises on the cycle after done.
  - A start in the DONE cycle is ignored.
- abort: in any state except IDLE, go to IDLE at the next edge.
  - No done pulse.
  - ke_load and ke_revers drop immediately on that next cycle.
  - abort in IDLE has no effect.
  - abort wins over a simultaneous start.
- Latency, start accepted at edge E0 (cycle k = k cycles after E0):
  - encrypt: ke_load in cycle 1; key_valid in cycles 2..Nr+2; done in cycle Nr+3.
  - decrypt: ke_load in cycle 1; EXPAND in cycles 2..Nr+1; key_valid in cycles Nr+2..2Nr+2; done in cycle 2Nr+3.
- Counter widths: round_idx and cnt are IDX_W bits and never exceed Nr, so no wrap-around occurs.

Test Plan:
- Reset mid-ROUND_FWD (mode 0, round_idx=5, RST_N low) -> all outputs 0 except ready=1 immediately; a new start is accepted normally after RST_N returns high.
- Mode 0 encrypt, start at E0 -> ke_load in cycle 1; key_valid in cycles 2..12 with round_idx 0..10; first_round in cycle 2; last_round in cycle 12; done in cycle 13; ready=1 in cycle 14.
- Mode 2 decrypt -> ke_mode=2; EXPAND in cycles 2..15; key_valid in cycles 16..30 with round_idx 14..0; ke_revers=1 in cycles 16..29 and 0 in cycle 30; done in cycle 31.
- Mode 1 encrypt with mode input changed to 0 in cycle 4 -> ke_mode stays 1; 13 key_valid cycles; last_round at round_idx=12.
- Abort during EXPAND (mode 1 decrypt, cycle 5) -> IDLE next cycle, no done, ke_revers never asserted; start with abort in the same cycle -> stays IDLE.
- Mode 3 encrypt -> behaves as mode 2: 15 key_valid cycles, ke_mode=2.
